// File: rtl/framebuffer_pixel_unpacker_if.sv
// Handshake bundle between the DDR read-word stream, the pixel unpacker and hdmi_xmitter.
// slave = unpacker view, master = the driving/consuming environment.
interface framebuffer_pixel_unpacker_if #(
    parameter int DW = 128
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          framebuffer_ready;
    logic          framebuffer_pull;
    logic [23:0]   framebuffer_data;
    logic          framebuffer_valid;

    modport slave (
        input  in_valid, in_data, framebuffer_pull,
        output in_ready, framebuffer_ready, framebuffer_data, framebuffer_valid
    );

    modport master (
        output in_valid, in_data, framebuffer_pull,
        input  in_ready, framebuffer_ready, framebuffer_data, framebuffer_valid
    );
endinterface

// File: rtl/framebuffer_pixel_unpacker.sv
// Unpacks 128-bit framebuffer words into RGB888 pixels (lane 0 first) with underrun flagging.
// Optional saturating underrun counter: define FB_UNPACK_UNDERRUN_CNT_EN.
module framebuffer_pixel_unpacker #(
    parameter int DW         = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_dvi,
    input  logic                          rst_n,
    input  logic                          flush,
    framebuffer_pixel_unpacker_if.slave   bus,
    output logic                          underrun,
    output logic [15:0]                   underrun_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_lane;
    logic [23:0]   r_data;
    logic          r_valid;
    logic          r_underrun;

    logic          w_in_ready;
    logic          w_fb_ready;
    logic          w_push;
    logic          w_hit;
    logic          w_pop;
    logic          w_miss;
    logic [DW-1:0] w_head;
    logic [23:0]   w_pixel;

    assign w_in_ready = (r_count < CW'(FIFO_DEPTH)) & ~flush;
    assign w_fb_ready = (r_count != '0);
    assign w_push     = bus.in_valid & w_in_ready;
    assign w_hit      = bus.framebuffer_pull & w_fb_ready & ~flush;
    assign w_pop      = w_hit & (r_lane == 2'd3);
    // A pull during flush is discarded, so it never counts as an underrun.
    assign w_miss     = bus.framebuffer_pull & ~w_fb_ready & ~flush;

    assign w_head  = r_mem[r_rptr];
    assign w_pixel = w_head[{r_lane, 5'd0} +: 24];

    assign bus.in_ready          = w_in_ready;
    assign bus.framebuffer_ready = w_fb_ready;
    assign bus.framebuffer_data  = r_data;
    assign bus.framebuffer_valid = r_valid;
    assign underrun              = r_underrun;

    always_ff @(posedge clk_dvi) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk_dvi or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_lane     <= 2'd0;
            r_data     <= 24'h000000;
            r_valid    <= 1'b0;
            r_underrun <= 1'b0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_lane  <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_hit) begin
                r_data  <= w_pixel;
                r_valid <= 1'b1;
                r_lane  <= r_lane + 2'd1;
            end else if (w_miss) begin
                r_data     <= 24'h000000;
                r_valid    <= 1'b1;
                r_underrun <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef FB_UNPACK_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_count;

    // Survives flush on purpose: only rst_n clears the statistic.
    always_ff @(posedge clk_dvi or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun_count <= 16'h0000;
        end else if (w_miss && (r_underrun_count != 16'hFFFF)) begin
            r_underrun_count <= r_underrun_count + 16'h0001;
        end
    end

    assign underrun_count = r_underrun_count;
`else
    assign underrun_count = 16'h0000;
`endif

endmodule

// File: doc/framebuffer_pixel_unpacker.md
# framebuffer_pixel_unpacker

Converts 128-bit framebuffer words read back from DDR into a stream of single RGB888 pixels on the `framebuffer_ready`/`framebuffer_pull`/`framebuffer_data`/`framebuffer_valid` interface consumed by `hdmi_xmitter`. It sits directly upstream of the transmitter in the `clk_dvi` domain, after the MIG read-data clock crossing. A small word FIFO absorbs read bursts. Pulls that arrive while no pixel is available are reported as underruns.

## Interface
- `DW`, 128: input word width; must equal `MIG_DATA_WIDTH`; 4 pixels per word.
- `FIFO_DEPTH`, 4: word FIFO depth; power of two, at least 2.
- `clk_dvi`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous clear of FIFO and lane state (frame boundary).
- `in_valid`  in  1  input word valid.
- `in_data`  in  DW  input word; pixel i = bits [32i+23:32i]; bits [32i+31:32i+24] ignored.
- `in_ready`  out  1  FIFO can accept a word.
- `framebuffer_ready`  out  1  at least one pixel available.
- `framebuffer_pull`  in  1  transmitter requests one pixel.
- `framebuffer_data`  out  24  `RGB888_t` pixel: r[23:16], g[15:8], b[7:0].
- `framebuffer_valid`  out  1  `framebuffer_data` holds the pixel for the previous pull.
- `underrun`  out  1  sticky flag: a pull arrived with no pixel available.
- `underrun_count`  out  16  saturating underrun count (see Configuration).

## Operation
- FIFO stores whole words; `count` is $clog2(FIFO_DEPTH)+1 bits wide; `lane` is a 2-bit index into the head word.
- Push occurs when `in_valid & in_ready`.
- `in_ready` = (`count` < `FIFO_DEPTH`) & ~`flush`.
- `framebuffer_ready` = (`count` != 0); combinational from registered `count`.
- Pull with `framebuffer_ready`:
  - register head word pixel[`lane`] to `framebuffer_data`; `framebuffer_valid`<=1.
  - `lane`<=`lane`+1, wrapping 3→0.
  - when `lane`==3, pop the head word.
- Pull without `framebuffer_ready`: `framebuffer_data`<=24'h000000, `framebuffer_valid`<=1, `underrun`<=1, counter increments. `lane` and FIFO are unchanged.
- No pull: `framebuffer_valid`<=0; `framebuffer_data` holds its value.
- Simultaneous push and pop: `count` is unchanged. Push at `count`==FIFO_DEPTH-1 with a pop in the same cycle is legal.
- `flush` takes priority over push and pull:
  - `count`<=0, `lane`<=0, `framebuffer_valid`<=0; any concurrent pull is dropped and is not an underrun.
  - `underrun` and `underrun_count` are not cleared.
- Pixel order: lane 0 (LSBs) first, lane 3 last.

## Timing
- Reset values (async, all registers): `count`=0, `lane`=0, FIFO pointers=0, `framebuffer_data`=0, `framebuffer_valid`=0, `underrun`=0, `underrun_count`=0. As a result, `in_ready`=1 and `framebuffer_ready`=0.
- Word accepted at edge N: `framebuffer_ready` is high in the cycle after N.
- Pull sampled at edge M: data/valid are visible after edge M, so latency is 1 cycle. Back-to-back pulls give one pixel per cycle.
- Final pop of a word at edge M with FIFO then empty: `framebuffer_ready` is low after M.
- Full FIFO: `in_ready` low. It rises in the cycle after the pop of lane 3.
- `rst_n` deasserted mid-frame: all state is lost and the upstream must restart from a frame boundary.

## Configuration
- `FB_UNPACK_UNDERRUN_CNT_EN` defined:
  - `underrun_count` increments on every underrun pull and saturates at 16'hFFFF.
  - cleared only by `rst_n`.
- `FB_UNPACK_UNDERRUN_CNT_EN` undefined: `underrun_count` is tied to 16'h0000 and no counter register exists. `underrun` is always present.

## Test plan
- Push {32'h1111_1111,32'h1111_1111,32'h1111_1111,32'hAAAA_AAAA}, then 4 consecutive pulls → data AAAAAA,111111,111111,111111 with valid=1 on each of the 4 following cycles; `framebuffer_ready` low after the 4th pull.
- Push 4 words with no pulls → `in_ready` low after the 4th push. A 5th word held valid is accepted in the cycle after the 4th pull.
- Pull with FIFO empty → data 000000, valid=1, `underrun`=1. With the macro, `underrun_count` goes 0→1; a further 70000 underruns leave it at FFFF.
- Continuous push at 1 word every 4 cycles against continuous pulls → no underrun, `count` stays ≤2, and the pixel sequence is in order.
- Assert `flush` with 3 words queued and `lane`=2, together with a pull → valid=0 next cycle, `framebuffer_ready`=0, no underrun. After a new push, the first pixel comes from lane 0.
- Drop `rst_n` mid-burst → all outputs return to their reset values immediately, without waiting for a clock edge.
